inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage that drives the read side of the instruction memory (rd_addr/rd_en) and hands each instruction to the decode stage over a valid/ready handshake.
- Holds the program counter and applies jump redirects from decode with zero bubble cycles.
- Stalls by deasserting rd_en, which relies on the memory's 1-cycle registered read holding rd_data while its enable is low.
- Sits between the instruction memory and axis_cpu decode/controller.

Parameters:
ADDR_WIDTH, 10, instruction address width; must match the instruction memory.
INST_WIDTH, 8, instruction word width; must match the instruction memory DATA_WIDTH.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: (re)start fetching at address 0
stop  in  1  pulse: stop issuing fetches
running  out  1  fetch engine active
rd_addr  out  ADDR_WIDTH  instruction memory read address
rd_en  out  1  instruction memory read enable
rd_data  in  INST_WIDTH  instruction memory read data, valid 1 cycle after rd_en
inst  out  INST_WIDTH  instruction to decode (= rd_data)
inst_pc  out  ADDR_WIDTH  address of inst
inst_valid  out  1  inst/inst_pc valid
inst_ready  in  1  decode accepts inst
jmp_en  in  1  redirect; honoured only when inst_valid & inst_ready
jmp_target  in  ADDR_WIDTH  redirect address

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n). On reset: running=0, inst_valid=0, inst_pc=0, pc=0. rd_en=0 because running=0.
- States are IDLE (running=0) and RUN (running=1).
- IDLE -> RUN on start.
- RUN -> IDLE on stop. A fetch already issued still completes, and inst_valid stays high until consumed.
- start has priority over stop.
- start in any state: next cycle running=1, pc=0, inst_valid=0. Any in-flight or unconsumed instruction is discarded. The first fetch (address 0) issues that next cycle.
- fire = inst_valid & inst_ready.
- rd_en = running & (~inst_valid | inst_ready), combinational.
- rd_addr = (fire & jmp_en) ? jmp_target : pc, combinational.
- When rd_en is high: pc <= rd_addr + 1, wrapping modulo 2^ADDR_WIDTH (max address wraps to 0); inst_pc <= rd_addr; inst_valid <= 1.
- When rd_en is low and fire: inst_valid <= 0.
- When rd_en is low and not fire: all fetch state holds.
- Latency: an instruction appears on inst 1 cycle after its rd_en cycle.
- Throughput: 1 instruction/cycle while inst_ready is held high.
- Stall: with inst_valid=1 and inst_ready=0, rd_en=0, so inst and inst_pc hold stable.
- Jump: jmp_en without fire is ignored. A jump fetch is issued in the accepting cycle, so the next inst is the target with no squashed slot. Jump while not running: pc updates, no fetch is issued.
- Memory writes to the instruction memory are allowed only while running=0. Fetch behaviour with concurrent writes is undefined.

Optional Feature:
- Macro: INST_FETCH_BOUND_CHECK_EN.
- With the macro defined, two extra ports exist:
  - prog_len in ADDR_WIDTH+1: number of valid instructions.
  - oob out 1: sticky error flag, reset 0, cleared by start.
- When running and rd_addr >= prog_len at a would-be fetch: no fetch is issued (rd_en=0), oob <= 1, running <= 0.
- prog_len = 2^ADDR_WIDTH disables the bound. prog_len = 0 trips on the first fetch.
- Without the macro: neither port exists and there is no bound checking.

Test Plan:
- Reset then start, inst_ready=1, memory[i]=i+1: rd_addr 0,1,2,... on consecutive cycles; inst 1,2,3 with inst_pc 0,1,2 one cycle later; inst_valid continuous.
- Hold inst_ready=0 for 3 cycles while inst_pc=2: rd_en=0, inst/inst_pc stable at address 2 contents; on release, inst_pc 3 follows next cycle.
- Accept inst_pc=4 with jmp_en=1, jmp_target=0x3F0: next inst_pc=0x3F0 with no bubble. Then 0x3F1... up to 0x3FF, and the sequence wraps to 0x000.
- stop while inst_valid=1, inst_ready=0: running=0, inst retained until accepted, then inst_valid=0 and no further rd_en. start with stop in the same cycle: fetch resumes at address 0.
- start mid-run at inst_pc=7: the next cycle has inst_valid=0; the cycle after has inst_pc=0.
- INST_FETCH_BOUND_CHECK_EN, prog_len=3: inst_pc 0,1,2 delivered, then oob=1 and running=0 with no fetch of address 3; start clears oob.

Source files
------------

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. Drives the read side of the instruction memory
// (rd_addr/rd_en) and presents each returned instruction to decode over a
// valid/ready handshake. Holds the program counter and applies jump redirects
// from decode in the accepting cycle, so a taken jump costs no bubble.
//
// Stalling works by dropping rd_en: the instruction memory has a 1-cycle
// registered read and keeps rd_data unchanged while its enable is low, so
// inst (= rd_data) and inst_pc stay stable while decode is not ready.
//
// Parameters:
//   ADDR_WIDTH  instruction address width (must match the instruction memory)
//   INST_WIDTH  instruction word width (must match the memory DATA_WIDTH)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: (re)start fetching at address 0 (beats stop)
//   stop              pulse: stop issuing fetches
//   running           fetch engine active
//   rd_addr, rd_en    instruction memory read address / enable
//   rd_data           instruction memory read data, 1 cycle after rd_en
//   inst, inst_pc     instruction to decode and its address
//   inst_valid        inst/inst_pc valid
//   inst_ready        decode accepts inst
//   jmp_en            redirect, honoured only when inst_valid & inst_ready
//   jmp_target        redirect address
//
// Optional feature (macro INST_FETCH_BOUND_CHECK_EN):
//   prog_len          number of valid instructions (2^ADDR_WIDTH disables)
//   oob               sticky out-of-bounds flag, cleared by start
//   A would-be fetch at rd_addr >= prog_len is suppressed, oob is set and
//   the engine stops.
// ----------------------------------------------------------------------------
module inst_fetch #(
    parameter int ADDR_WIDTH = 10,
    parameter int INST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    output logic                  running,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [INST_WIDTH-1:0] rd_data,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  jmp_en,
    input  logic [ADDR_WIDTH-1:0] jmp_target
`ifdef INST_FETCH_BOUND_CHECK_EN
    ,
    input  logic [ADDR_WIDTH:0]   prog_len,
    output logic                  oob
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fire;
    logic                  jump_fire;
    logic                  fetch_want;
    logic                  oob_hit;

    assign running    = (state_q == RUN);
    assign fire       = inst_valid & inst_ready;
    assign jump_fire  = fire & jmp_en;
    // A fetch is wanted whenever the output slot is empty or being emptied.
    assign fetch_want = running & (~inst_valid | inst_ready);
    // The jump target is fetched in the accepting cycle itself.
    assign rd_addr    = jump_fire ? jmp_target : pc;
    assign inst       = rd_data;

`ifdef INST_FETCH_BOUND_CHECK_EN
    assign oob_hit = fetch_want & ({1'b0, rd_addr} >= prog_len);
`else
    assign oob_hit = 1'b0;
`endif

    assign rd_en = fetch_want & ~oob_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    state_d = RUN;
                end else if (stop || oob_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // start discards anything in flight: the fetch issued in the start cycle
    // (if any) is dropped by clearing inst_valid instead of capturing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (start) begin
            pc         <= '0;
            inst_valid <= 1'b0;
        end else if (rd_en) begin
            pc         <= rd_addr + ADDR_WIDTH'(1);
            inst_pc    <= rd_addr;
            inst_valid <= 1'b1;
        end else if (fire) begin
            inst_valid <= 1'b0;
            // Jump accepted while no fetch can issue: only the pc moves.
            if (jmp_en) begin
                pc <= jmp_target;
            end
        end
    end

`ifdef INST_FETCH_BOUND_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob <= 1'b0;
        end else if (start) begin
            oob <= 1'b0;
        end else if (oob_hit) begin
            oob <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
module tb_inst_fetch;

    localparam int AW = 10;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          running;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [IW-1:0] rd_data;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic          jmp_en = 1'b0;
    logic [AW-1:0] jmp_target = '0;
`ifdef INST_FETCH_BOUND_CHECK_EN
    logic [AW:0]   prog_len = (AW+1)'(1 << AW);
    logic          oob;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [IW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    // Instruction memory: 1-cycle registered read, holds data while rd_en=0.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    inst_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .running    (running),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .jmp_en     (jmp_en),
        .jmp_target (jmp_target)
`ifdef INST_FETCH_BOUND_CHECK_EN
        ,
        .prog_len   (prog_len),
        .oob        (oob)
`endif
    );

    task automatic fill_mem_linear();
        for (int i = 0; i < (1 << AW); i++) mem[i] = IW'(i + 1);
    endtask

    task automatic stop_and_drain();
        @(negedge clk);
        stop = 1'b1; start = 1'b0; inst_ready = 1'b1; jmp_en = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({running, inst_valid, rd_en} !== 3'b000) begin
            n_errors++;
            $display("[TB] FAIL drain_idle: got run/valid/en=%b required 000", {running, inst_valid, rd_en});
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_checks++;
        if ({running, inst_valid, rd_en} !== 3'b000 || inst_pc !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_state: got run/valid/en=%b pc=%h required 000 pc=000", {running, inst_valid, rd_en}, inst_pc);
        end
`ifdef INST_FETCH_BOUND_CHECK_EN
        n_checks++;
        if (oob !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_oob: got %b required 0", oob);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({running, rd_en} !== 2'b00) begin
            n_errors++;
            $display("[TB] FAIL post_reset_idle: got run/en=%b required 00", {running, rd_en});
        end
    endtask

    task automatic test_sequential();
        @(negedge clk);
        start = 1'b1; inst_ready = 1'b1; jmp_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if ({running, inst_valid, rd_en} !== 3'b101 || rd_addr !== '0) begin
            n_errors++;
            $display("[TB] FAIL seq_first_fetch: got run/valid/en=%b addr=%h required 101 addr=000", {running, inst_valid, rd_en}, rd_addr);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (rd_en !== 1'b1 || rd_addr !== AW'(i) || inst_valid !== 1'b1 ||
                inst_pc !== AW'(i - 1) || inst !== IW'(i)) begin
                n_errors++;
                $display("[TB] FAIL seq_step%0d: got en=%b addr=%h valid=%b pc=%h inst=%h required en=1 addr=%h valid=1 pc=%h inst=%h",
                         i, rd_en, rd_addr, inst_valid, inst_pc, inst, AW'(i), AW'(i - 1), IW'(i));
            end
        end
    endtask

    // Entered with inst_pc=2 on the outputs.
    task automatic test_stall();
        inst_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (rd_en !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== AW'(2) || inst !== IW'(3)) begin
                n_errors++;
                $display("[TB] FAIL stall_hold%0d: got en=%b valid=%b pc=%h inst=%h required en=0 valid=1 pc=002 inst=03",
                         k, rd_en, inst_valid, inst_pc, inst);
            end
        end
        inst_ready = 1'b1;
        #1;
        n_checks++;
        if (rd_en !== 1'b1 || rd_addr !== AW'(3)) begin
            n_errors++;
            $display("[TB] FAIL stall_release: got en=%b addr=%h required en=1 addr=003", rd_en, rd_addr);
        end
        @(negedge clk); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== AW'(3) || inst !== IW'(4)) begin
            n_errors++;
            $display("[TB] FAIL stall_next: got valid=%b pc=%h inst=%h required valid=1 pc=003 inst=04", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_jump();
        logic [AW-1:0] epc;
        @(negedge clk); #1;
        n_checks++;
        if (inst_pc !== AW'(4) || inst_valid !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL jump_pre: got pc=%h valid=%b required pc=004 valid=1", inst_pc, inst_valid);
        end
        jmp_en = 1'b1; jmp_target = AW'(10'h3F0);
        #1;
        n_checks++;
        if (rd_en !== 1'b1 || rd_addr !== AW'(10'h3F0)) begin
            n_errors++;
            $display("[TB] FAIL jump_fetch: got en=%b addr=%h required en=1 addr=3f0", rd_en, rd_addr);
        end
        @(negedge clk);
        jmp_en = 1'b0;
        #1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            epc = AW'(10'h3F0 + k);
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== epc || inst !== IW'(epc + 1)) begin
                n_errors++;
                $display("[TB] FAIL jump_seq%0d: got valid=%b pc=%h inst=%h required valid=1 pc=%h inst=%h",
                         k, inst_valid, inst_pc, inst, epc, IW'(epc + 1));
            end
        end
    endtask

    // Entered with inst_pc=0 presented and inst_ready=1.
    task automatic test_stop();
        inst_ready = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_checks++;
            if ({running, inst_valid, rd_en} !== 3'b010 || inst_pc !== '0 || inst !== IW'(1)) begin
                n_errors++;
                $display("[TB] FAIL stop_retain%0d: got run/valid/en=%b pc=%h inst=%h required 010 pc=000 inst=01",
                         k, {running, inst_valid, rd_en}, inst_pc, inst);
            end
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_checks++;
            if (rd_en !== 1'b0 || running !== 1'b0 || (k > 0 && inst_valid !== 1'b0)) begin
                n_errors++;
                $display("[TB] FAIL stop_drain%0d: got run=%b valid=%b en=%b required run=0 en=0 valid=%0d",
                         k, running, inst_valid, rd_en, (k > 0) ? 0 : 1);
            end
        end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        #1;
        n_checks++;
        if ({running, inst_valid, rd_en} !== 3'b101 || rd_addr !== '0) begin
            n_errors++;
            $display("[TB] FAIL start_over_stop: got run/valid/en=%b addr=%h required 101 addr=000", {running, inst_valid, rd_en}, rd_addr);
        end
        @(negedge clk); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== '0 || inst !== IW'(1)) begin
            n_errors++;
            $display("[TB] FAIL start_over_stop_inst: got valid=%b pc=%h inst=%h required valid=1 pc=000 inst=01", inst_valid, inst_pc, inst);
        end
    endtask

    // Entered with inst_pc=0 presented and inst_ready=1.
    task automatic test_restart();
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== AW'(i)) begin
                n_errors++;
                $display("[TB] FAIL restart_run%0d: got valid=%b pc=%h required valid=1 pc=%h", i, inst_valid, inst_pc, AW'(i));
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if ({running, inst_valid} !== 2'b10 || rd_addr !== '0) begin
            n_errors++;
            $display("[TB] FAIL restart_flush: got run/valid=%b addr=%h required 10 addr=000", {running, inst_valid}, rd_addr);
        end
        @(negedge clk); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== '0 || inst !== IW'(1)) begin
            n_errors++;
            $display("[TB] FAIL restart_first: got valid=%b pc=%h inst=%h required valid=1 pc=000 inst=01", inst_valid, inst_pc, inst);
        end
    endtask

    // Random ready/jump traffic checked against an instruction-stream model:
    // each accepted instruction determines the address of the next one.
    task automatic test_random();
        logic [AW-1:0] exp_next;
        logic [AW-1:0] held_pc;
        logic [IW-1:0] held_inst;
        logic [AW-1:0] cur_pc;
        logic          prev_valid;
        logic          prev_fire;
        logic          fire_now;
        stop_and_drain();
        for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_next = '0; held_pc = '0; held_inst = '0;
        prev_valid = 1'b0; prev_fire = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (n > 0) @(negedge clk);
            inst_ready = ($urandom_range(0, 3) != 0);
            jmp_en     = ($urandom_range(0, 7) == 0);
            jmp_target = AW'($urandom_range(0, (1 << AW) - 1));
            #1;
            if (n == 0 || !prev_valid || prev_fire) begin
                n_checks++;
                if (inst_valid !== ((n == 0) ? 1'b0 : 1'b1)) begin
                    n_errors++;
                    $display("[TB] FAIL rand_valid@%0d: got %b required %0d", n, inst_valid, (n == 0) ? 0 : 1);
                end
            end
            cur_pc = held_pc;
            if (inst_valid === 1'b1) begin
                n_checks++;
                if (prev_valid && !prev_fire) begin
                    if (inst_pc !== held_pc || inst !== held_inst) begin
                        n_errors++;
                        $display("[TB] FAIL rand_hold@%0d: got pc=%h inst=%h required pc=%h inst=%h", n, inst_pc, inst, held_pc, held_inst);
                    end
                end else begin
                    cur_pc = exp_next;
                    held_pc = exp_next;
                    held_inst = mem[exp_next];
                    if (inst_pc !== exp_next || inst !== mem[exp_next]) begin
                        n_errors++;
                        $display("[TB] FAIL rand_stream@%0d: got pc=%h inst=%h required pc=%h inst=%h", n, inst_pc, inst, exp_next, mem[exp_next]);
                    end
                end
                if (!inst_ready) begin
                    n_checks++;
                    if (rd_en !== 1'b0) begin
                        n_errors++;
                        $display("[TB] FAIL rand_stall_en@%0d: got %b required 0", n, rd_en);
                    end
                end
            end
            fire_now = (inst_valid === 1'b1) && inst_ready;
            if (fire_now) exp_next = jmp_en ? jmp_target : AW'(cur_pc + 1);
            prev_valid = (inst_valid === 1'b1);
            prev_fire  = fire_now;
        end
        jmp_en = 1'b0;
        stop_and_drain();
    endtask

`ifdef INST_FETCH_BOUND_CHECK_EN
    task automatic test_bound();
        fill_mem_linear();
        @(negedge clk);
        prog_len = (AW+1)'(3); start = 1'b1; inst_ready = 1'b1; jmp_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if (rd_en !== 1'b1 || rd_addr !== '0 || oob !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL bound_first: got en=%b addr=%h oob=%b required en=1 addr=000 oob=0", rd_en, rd_addr, oob);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== AW'(i - 1) || inst !== IW'(i) ||
                rd_en !== ((i < 3) ? 1'b1 : 1'b0)) begin
                n_errors++;
                $display("[TB] FAIL bound_deliver%0d: got valid=%b pc=%h inst=%h en=%b required valid=1 pc=%h inst=%h en=%0d",
                         i, inst_valid, inst_pc, inst, rd_en, AW'(i - 1), IW'(i), (i < 3) ? 1 : 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({oob, running, inst_valid, rd_en} !== 4'b1000) begin
                n_errors++;
                $display("[TB] FAIL bound_trip%0d: got oob/run/valid/en=%b required 1000", k, {oob, running, inst_valid, rd_en});
            end
        end
        prog_len = (AW+1)'(1 << AW); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if ({oob, running, rd_en} !== 3'b011) begin
            n_errors++;
            $display("[TB] FAIL bound_clear: got oob/run/en=%b required 011", {oob, running, rd_en});
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fill_mem_linear();
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_stop();
        test_restart();
        test_random();
`ifdef INST_FETCH_BOUND_CHECK_EN
        test_bound();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
